// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase and BCD digit chain.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX_UNITS    = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_TENS_SEC = 4'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  // clear dominates start_stop; start_stop toggles between RUN and PAUSED.
  function automatic state_t state_after(input state_t cur,
                                         input logic   start_stop,
                                         input logic   clear);
    state_t nxt;
    nxt = cur;
    if (clear) begin
      nxt = IDLE;
    end else if (start_stop) begin
      case (cur)
        IDLE:    nxt = RUN;
        RUN:     nxt = PAUSED;
        PAUSED:  nxt = RUN;
        default: nxt = IDLE;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit with synchronous clear, increment and ripple carry out at MAX.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = BCD_MAX_UNITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  assign carry = inc && (q == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == MAX) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timebase: prescaler, run/pause/idle FSM and SS.hh BCD digit chain.
// Optional lap hold display register enabled by defining LAP_HOLD_EN.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               lap,
  output logic [DIGIT_W-1:0] q0,
  output logic [DIGIT_W-1:0] q1,
  output logic [DIGIT_W-1:0] q2,
  output logic [DIGIT_W-1:0] q3,
  output logic               running,
  output logic               wrap
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PRESC_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  state_t               state;
  state_t               state_nx;
  logic [PRESC_W-1:0]   presc;
  logic                 tick;
  logic [DIGIT_W-1:0]   d0, d1, d2, d3;
  logic                 c0, c1, c2, c3;

  assign state_nx = state_after(state, start_stop, clear);
  assign tick     = (state == RUN) && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == RUN);
      wrap    <= c3 && !clear;
    end
  end

  // PAUSED keeps the partial count so a resume does not lose sub-tick time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear || (state == IDLE)) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  bcd_digit #(.MAX(BCD_MAX_UNITS)) u_hundredths (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clear),
    .inc  (tick),
    .q    (d0),
    .carry(c0)
  );

  bcd_digit #(.MAX(BCD_MAX_UNITS)) u_tenths (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clear),
    .inc  (c0),
    .q    (d1),
    .carry(c1)
  );

  bcd_digit #(.MAX(BCD_MAX_UNITS)) u_sec_units (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clear),
    .inc  (c1),
    .q    (d2),
    .carry(c2)
  );

  bcd_digit #(.MAX(BCD_MAX_TENS_SEC)) u_sec_tens (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clear),
    .inc  (c2),
    .q    (d3),
    .carry(c3)
  );

`ifdef LAP_HOLD_EN
  logic               hold;
  logic [DIGIT_W-1:0] s0, s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= 1'b0;
      s0   <= '0;
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
    end else if (clear) begin
      hold <= 1'b0;
    end else if (lap && (state != IDLE)) begin
      hold <= !hold;
      if (!hold) begin
        s0 <= d0;
        s1 <= d1;
        s2 <= d2;
        s3 <= d3;
      end
    end
  end

  assign q0 = hold ? s0 : d0;
  assign q1 = hold ? s1 : d1;
  assign q2 = hold ? s2 : d2;
  assign q3 = hold ? s3 : d3;
`else
  logic unused_lap;
  assign unused_lap = lap;

  assign q0 = d0;
  assign q1 = d1;
  assign q2 = d2;
  assign q3 = d3;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboarded bench for stopwatch_counter with DIV=10 (CLK_HZ=10, TICK_HZ=1).
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] q0, q1, q2, q3;
  logic       running;
  logic       wrap;

  stopwatch_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .running   (running),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; stable at every falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       name;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   finish_req = 1'b0;

  task automatic expect_at(input int at, input string name, input logic [15:0] digits,
                           input logic run, input logic wr);
    exp_t e;
    int   i;
    e.at   = at;
    e.name = name;
    e.v    = {digits, run, wr};
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  exp_t        cur;
  logic [17:0] got;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      got = {q3, q2, q1, q0, running, wrap};
      checks++;
      if (cur.at != cyc || got !== cur.v) begin
        errors++;
        $display("FAIL %s cyc=%0d(want %0d) got q=%h%h.%h%h run=%b wrap=%b want q=%h%h.%h%h run=%b wrap=%b",
                 cur.name, cyc, cur.at, got[17:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
                 cur.v[17:14], cur.v[13:10], cur.v[9:6], cur.v[5:2], cur.v[1], cur.v[0]);
      end
    end
    if (finish_req) begin
      if (sb.size() > 0) begin
        checks += sb.size();
        errors += sb.size();
        $display("FAIL leftover %0d expectations never reached", sb.size());
        sb.delete();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive the pulses so they are sampled on rising edge number e.
  task automatic pulse(input int e, input bit ss, input bit cl, input bit lp);
    wait_cyc(e - 1);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  localparam int T0 = 6;
  localparam int TW = T0 + 60010;
  localparam int R  = TW + 54;
  localparam int C  = R + 20;
  localparam int S2 = C + 20;
  localparam int P  = S2 + 30;
  localparam int S3 = P + 5;
  localparam int S4 = S3 + 100;

  initial begin
    rst_n      = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;

    expect_at(2, "in_reset", 16'h0000, 1'b0, 1'b0);
    expect_at(4, "after_reset", 16'h0000, 1'b0, 1'b0);
    expect_at(5, "idle_before_start", 16'h0000, 1'b0, 1'b0);
    expect_at(T0, "running_next_cycle", 16'h0000, 1'b1, 1'b0);
    expect_at(T0 + 9, "no_tick_before_div", 16'h0000, 1'b1, 1'b0);
    expect_at(T0 + 10, "first_tick_at_div", 16'h0001, 1'b1, 1'b0);
    expect_at(T0 + 99, "pre_tenths_carry", 16'h0009, 1'b1, 1'b0);
    expect_at(T0 + 100, "tenths_carry", 16'h0010, 1'b1, 1'b0);
    expect_at(T0 + 9990, "at_09_99", 16'h0999, 1'b1, 1'b0);
    expect_at(T0 + 10000, "carry_to_10_00", 16'h1000, 1'b1, 1'b0);
    expect_at(T0 + 59990, "at_59_99", 16'h5999, 1'b1, 1'b0);
    expect_at(T0 + 59999, "no_wrap_yet", 16'h5999, 1'b1, 1'b0);
    expect_at(T0 + 60000, "wrap_pulse", 16'h0000, 1'b1, 1'b1);
    expect_at(T0 + 60001, "wrap_one_cycle", 16'h0000, 1'b1, 1'b0);
    expect_at(TW, "count_after_wrap", 16'h0001, 1'b1, 1'b0);

    wait_cyc(3);
    rst_n = 1'b1;
    pulse(T0, 1'b1, 1'b0, 1'b0);

    expect_at(TW + 4, "paused", 16'h0001, 1'b0, 1'b0);
    expect_at(TW + 30, "paused_hold", 16'h0001, 1'b0, 1'b0);
    expect_at(TW + 53, "paused_end", 16'h0001, 1'b0, 1'b0);
    expect_at(R, "resumed", 16'h0001, 1'b1, 1'b0);
    expect_at(R + 5, "resume_partial", 16'h0001, 1'b1, 1'b0);
    expect_at(R + 6, "resume_tick_6", 16'h0002, 1'b1, 1'b0);
    expect_at(R + 16, "resume_next_tick", 16'h0003, 1'b1, 1'b0);
    pulse(TW + 4, 1'b1, 1'b0, 1'b0);
    pulse(R, 1'b1, 1'b0, 1'b0);

    expect_at(C - 1, "before_clear", 16'h0003, 1'b1, 1'b0);
    expect_at(C, "clear_wins", 16'h0000, 1'b0, 1'b0);
    expect_at(C + 15, "idle_stays", 16'h0000, 1'b0, 1'b0);
    expect_at(S2, "restart", 16'h0000, 1'b1, 1'b0);
    expect_at(S2 + 20, "restart_two_ticks", 16'h0002, 1'b1, 1'b0);
    expect_at(S2 + 26, "paused_again", 16'h0002, 1'b0, 1'b0);
    expect_at(P, "clear_in_paused", 16'h0000, 1'b0, 1'b0);
    expect_at(S3 + 9, "presc_zeroed_by_clear", 16'h0000, 1'b1, 1'b0);
    expect_at(S3 + 10, "tick_after_clear", 16'h0001, 1'b1, 1'b0);
    pulse(C, 1'b1, 1'b1, 1'b0);
    pulse(S2, 1'b1, 1'b0, 1'b0);
    pulse(S2 + 25, 1'b1, 1'b0, 1'b0);
    pulse(P, 1'b0, 1'b1, 1'b0);
    pulse(S3, 1'b1, 1'b0, 1'b0);

    expect_at(S3 + 50, "lap_before", 16'h0005, 1'b1, 1'b0);
`ifdef LAP_HOLD_EN
    expect_at(S3 + 52, "lap_frozen", 16'h0005, 1'b1, 1'b0);
    expect_at(S3 + 60, "lap_frozen_t1", 16'h0005, 1'b1, 1'b0);
    expect_at(S3 + 70, "lap_frozen_t2", 16'h0005, 1'b1, 1'b0);
    expect_at(S3 + 81, "lap_frozen_t3", 16'h0005, 1'b1, 1'b0);
`else
    expect_at(S3 + 52, "lap_live", 16'h0005, 1'b1, 1'b0);
    expect_at(S3 + 60, "lap_live_t1", 16'h0006, 1'b1, 1'b0);
    expect_at(S3 + 70, "lap_live_t2", 16'h0007, 1'b1, 1'b0);
    expect_at(S3 + 81, "lap_live_t3", 16'h0008, 1'b1, 1'b0);
`endif
    expect_at(S3 + 82, "lap_release", 16'h0008, 1'b1, 1'b0);
    expect_at(S3 + 90, "lap_live_again", 16'h0009, 1'b1, 1'b0);
    expect_at(S3 + 94, "lap_rehold", 16'h0009, 1'b1, 1'b0);
    expect_at(S3 + 95, "clear_releases", 16'h0000, 1'b0, 1'b0);
    expect_at(S4 + 10, "live_after_clear", 16'h0001, 1'b1, 1'b0);
    expect_at(S4 + 15, "async_reset", 16'h0000, 1'b0, 1'b0);
    expect_at(S4 + 29, "post_reset_no_tick", 16'h0000, 1'b1, 1'b0);
    expect_at(S4 + 30, "post_reset_tick", 16'h0001, 1'b1, 1'b0);
    pulse(S3 + 52, 1'b0, 1'b0, 1'b1);
    pulse(S3 + 82, 1'b0, 1'b0, 1'b1);
    pulse(S3 + 93, 1'b0, 1'b0, 1'b1);
    pulse(S3 + 95, 1'b0, 1'b1, 1'b0);
    pulse(S4, 1'b1, 1'b0, 1'b0);

    // Reset asserted between edges with prescaler partway through a period.
    wait_cyc(S4 + 14);
    #2 rst_n = 1'b0;
    wait_cyc(S4 + 16);
    rst_n = 1'b1;
    pulse(S4 + 20, 1'b1, 1'b0, 1'b0);

    wait_cyc(S4 + 33);
    finish_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("FAIL monitor did not finish");
    $fatal(1);
  end

endmodule
